// File: rtl/composite_video_pkg.sv
// Shared types and NTSC default timings for the composite sync generator.
package composite_video_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VERT,
      ST_BLANK,
      ST_ACTIVE,
      ST_HALF
   } state_t;

   // Vertical interval: 9 lines = 18 half-lines; lines 3..5 carry the serrated broad pulses.
   localparam int VERT_LINES = 9;
   localparam int SERR_FIRST = 3;
   localparam int SERR_END   = 6;

   localparam int NTSC_LINE_CYC    = 3180;
   localparam int NTSC_HSYNC_CYC   = 235;
   localparam int NTSC_EQ_CYC      = 115;
   localparam int NTSC_ACT_START   = 469;
   localparam int NTSC_ACT_END     = 3099;
   localparam int NTSC_BLANK_LINES = 11;
   localparam int NTSC_ACT_LINES   = 242;

   localparam logic [7:0] NTSC_SYNC_LVL  = 8'h00;
   localparam logic [7:0] NTSC_BLANK_LVL = 8'h7F;
   localparam logic [7:0] NTSC_BLACK_LVL = 8'h8A;

endpackage

// File: rtl/video_line_timer.sv
// Horizontal cycle counter with full/half-line wrap and sync pulse-width compares.
module video_line_timer #(
   parameter int CW        = 12,
   parameter int LINE_CYC  = 3180,
   parameter int HSYNC_CYC = 235,
   parameter int EQ_CYC    = 115
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   input  logic          half_mode,
   output logic [CW-1:0] x,
   output logic          line_end,
   output logic          hsync_pulse,
   output logic          eq_pulse,
   output logic          broad_pulse
);
   localparam int H = LINE_CYC / 2;
   localparam logic [CW-1:0] LAST_FULL = CW'(LINE_CYC - 1);
   localparam logic [CW-1:0] LAST_HALF = CW'(H - 1);
   localparam logic [CW-1:0] HALF_X    = CW'(H);
   localparam logic [CW-1:0] HS_W      = CW'(HSYNC_CYC);
   localparam logic [CW-1:0] EQ_W      = CW'(EQ_CYC);
   localparam logic [CW-1:0] BROAD_W   = CW'(H - HSYNC_CYC);

   logic [CW-1:0] xh;

   // Equalising and broad pulses repeat every half-line, so compare against the offset in the half.
   assign xh          = (x >= HALF_X) ? x - HALF_X : x;
   assign line_end    = (x == (half_mode ? LAST_HALF : LAST_FULL));
   assign hsync_pulse = (x < HS_W);
   assign eq_pulse    = (xh < EQ_W);
   assign broad_pulse = (xh < BROAD_W);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         x <= '0;
      else if (!run || line_end)
         x <= '0;
      else
         x <= x + CW'(1);
   end

endmodule

// File: rtl/composite_sync_gen.sv
// Composite video timing and DAC level generator (progressive or 2-field interlace).
// Internal counters run one cycle ahead; every output is registered from that look-ahead position.
module composite_sync_gen
   import composite_video_pkg::*;
#(
   parameter int DW          = 8,
   parameter int CW          = 12,
   parameter int LW          = 10,
   parameter int LINE_CYC    = NTSC_LINE_CYC,
   parameter int HSYNC_CYC   = NTSC_HSYNC_CYC,
   parameter int EQ_CYC      = NTSC_EQ_CYC,
   parameter int ACT_START   = NTSC_ACT_START,
   parameter int ACT_END     = NTSC_ACT_END,
   parameter int BLANK_LINES = NTSC_BLANK_LINES,
   parameter int ACT_LINES   = NTSC_ACT_LINES,
   parameter int INTERLACE   = 0,
   parameter logic [DW-1:0] SYNC_LVL  = DW'(NTSC_SYNC_LVL),
   parameter logic [DW-1:0] BLANK_LVL = DW'(NTSC_BLANK_LVL),
   parameter logic [DW-1:0] BLACK_LVL = DW'(NTSC_BLACK_LVL)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [DW-1:0] pix_data,
   output logic          pix_req,
   output logic [DW-1:0] dac,
   output logic          sync_n,
   output logic          active,
   output logic          field,
   output logic [LW-1:0] line,
   output logic [CW-1:0] xpos,
   output logic          frame_start
);
   localparam logic [LW-1:0] L_VERT_LAST  = LW'(VERT_LINES - 1);
   localparam logic [LW-1:0] L_BLANK_LAST = LW'(VERT_LINES + BLANK_LINES - 1);
   localparam logic [LW-1:0] L_FIELD_LAST = LW'(VERT_LINES + BLANK_LINES + ACT_LINES - 1);
   localparam logic [LW-1:0] L_SERR_FIRST = LW'(SERR_FIRST);
   localparam logic [LW-1:0] L_SERR_END   = LW'(SERR_END);
   localparam logic [CW-1:0] X_REQ_FIRST  = CW'(ACT_START - 1);
   localparam logic [CW-1:0] X_REQ_LAST   = CW'(ACT_END - 2);
   localparam logic [CW-1:0] X_ACT_FIRST  = CW'(ACT_START);
   localparam logic [CW-1:0] X_ACT_END    = CW'(ACT_END);

   state_t        state, ph;
   logic [LW-1:0] line_c;
   logic          field_c;
   logic [CW-1:0] x;
   logic          line_end, hsync_pulse, eq_pulse, broad_pulse;
   logic          sync_c, video_c, req_c, fs_c, pix_req_r;
   logic [DW-1:0] pix_clamped;

   video_line_timer #(
      .CW(CW), .LINE_CYC(LINE_CYC), .HSYNC_CYC(HSYNC_CYC), .EQ_CYC(EQ_CYC)
   ) u_timer (
      .clk(clk), .reset(reset), .run(enable), .half_mode(ph == ST_HALF),
      .x(x), .line_end(line_end), .hsync_pulse(hsync_pulse),
      .eq_pulse(eq_pulse), .broad_pulse(broad_pulse)
   );

   // IDLE parks the look-ahead at the start of the vertical interval so run-up is immediate.
   always_comb begin
      ph = (state == ST_IDLE) ? ST_VERT : state;
      sync_c = hsync_pulse;
      if (ph == ST_VERT)
         sync_c = (line_c >= L_SERR_FIRST && line_c < L_SERR_END) ? broad_pulse : eq_pulse;
      video_c = (ph == ST_ACTIVE) && (x >= X_ACT_FIRST) && (x < X_ACT_END);
      req_c   = (ph == ST_ACTIVE) && (x >= X_REQ_FIRST) && (x <= X_REQ_LAST);
      fs_c    = (ph == ST_VERT) && (line_c == '0) && (x == '0) && !field_c;
      pix_clamped = (pix_data > BLACK_LVL) ? pix_data : BLACK_LVL;
   end

   assign pix_req = pix_req_r & enable;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         line_c      <= '0;
         field_c     <= 1'b0;
         dac         <= BLANK_LVL;
         sync_n      <= 1'b1;
         active      <= 1'b0;
         pix_req_r   <= 1'b0;
         field       <= 1'b0;
         line        <= '0;
         xpos        <= '0;
         frame_start <= 1'b0;
      end else begin
         if (!enable) begin
            state   <= ST_IDLE;
            line_c  <= '0;
            field_c <= 1'b0;
         end else if (!line_end) begin
            state <= ph;
         end else begin
            case (ph)
               ST_VERT: begin
                  line_c <= line_c + LW'(1);
                  state  <= (line_c == L_VERT_LAST) ? ST_BLANK : ST_VERT;
               end
               ST_BLANK: begin
                  line_c <= line_c + LW'(1);
                  state  <= (line_c == L_BLANK_LAST) ? ST_ACTIVE : ST_BLANK;
               end
               ST_ACTIVE: begin
                  if (line_c != L_FIELD_LAST) begin
                     line_c <= line_c + LW'(1);
                     state  <= ST_ACTIVE;
                  end else if (INTERLACE != 0 && !field_c) begin
                     line_c <= line_c + LW'(1);
                     state  <= ST_HALF;
                  end else begin
                     line_c  <= '0;
                     field_c <= (INTERLACE != 0) ? !field_c : 1'b0;
                     state   <= ST_VERT;
                  end
               end
               ST_HALF: begin
                  line_c  <= '0;
                  field_c <= 1'b1;
                  state   <= ST_VERT;
               end
               default: state <= ST_IDLE;
            endcase
         end

         // pix_data is sampled while the previous output cycle had pix_req high.
         dac         <= (!enable) ? BLANK_LVL : sync_c ? SYNC_LVL : video_c ? pix_clamped : BLANK_LVL;
         sync_n      <= !(enable && sync_c);
         active      <= enable && video_c;
         pix_req_r   <= enable && req_c;
         field       <= enable && field_c;
         line        <= enable ? line_c : '0;
         xpos        <= enable ? x : '0;
         frame_start <= enable && fs_c;
      end
   end

endmodule
